// File: rtl/exe_unit_arbiter_pkg.sv
// exe_arb_pkg: shared types for the two-requester execution unit arbiter.
// Optional statistics counters are enabled with the EXE_ARB_STATS_EN macro.
package exe_arb_pkg;

  localparam int STATUS_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/exe_unit_arbiter_if.sv
// exe_unit_arbiter_if: request, response and execution-unit signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
// With EXE_ARB_STATS_EN defined the per-requester grant counters are carried here too.
interface exe_unit_arbiter_if
  import exe_arb_pkg::*;
#(
  parameter int m     = 4,
  parameter int n     = 2,
  parameter int CNT_W = 16
);

  logic                  i_req0_valid;
  logic                  o_req0_ready;
  logic [n-1:0]          i_req0_oper;
  logic signed [m-1:0]   i_req0_argA;
  logic signed [m-1:0]   i_req0_argB;

  logic                  i_req1_valid;
  logic                  o_req1_ready;
  logic [n-1:0]          i_req1_oper;
  logic signed [m-1:0]   i_req1_argA;
  logic signed [m-1:0]   i_req1_argB;

  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  req_id_t               o_rsp_id;
  logic [m-1:0]          o_rsp_result;
  logic [STATUS_W-1:0]   o_rsp_status;

  logic [n-1:0]          o_eu_oper;
  logic signed [m-1:0]   o_eu_argA;
  logic signed [m-1:0]   o_eu_argB;
  logic [m-1:0]          i_eu_result;
  logic [STATUS_W-1:0]   i_eu_status;

  logic                  o_busy;

`ifdef EXE_ARB_STATS_EN
  logic [CNT_W-1:0]      o_cnt0;
  logic [CNT_W-1:0]      o_cnt1;
`endif

  modport slave (
    input  i_req0_valid, i_req0_oper, i_req0_argA, i_req0_argB,
    input  i_req1_valid, i_req1_oper, i_req1_argA, i_req1_argB,
    input  i_rsp_ready, i_eu_result, i_eu_status,
    output o_req0_ready, o_req1_ready,
    output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status,
    output o_eu_oper, o_eu_argA, o_eu_argB,
    output o_busy
`ifdef EXE_ARB_STATS_EN
    , output o_cnt0, o_cnt1
`endif
  );

  modport master (
    output i_req0_valid, i_req0_oper, i_req0_argA, i_req0_argB,
    output i_req1_valid, i_req1_oper, i_req1_argA, i_req1_argB,
    output i_rsp_ready, i_eu_result, i_eu_status,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status,
    input  o_eu_oper, o_eu_argA, o_eu_argB,
    input  o_busy
`ifdef EXE_ARB_STATS_EN
    , input o_cnt0, o_cnt1
`endif
  );

endinterface

// File: rtl/exe_unit_arbiter_rr.sv
// rr_arbiter2: combinational two-way round-robin grant.
// A lone requester always wins; when both ask, the one that did not win last time wins.
module rr_arbiter2
  import exe_arb_pkg::*;
(
  input  logic    valid0,
  input  logic    valid1,
  input  req_id_t last,
  output logic    grant0,
  output logic    grant1,
  output req_id_t winner
);

  // pick the winner from the two valids and the previous winner
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    winner = 1'b0;
    if (valid0 && valid1) begin
      if (last == 1'b1) begin
        grant0 = 1'b1;
        winner = 1'b0;
      end else begin
        grant1 = 1'b1;
        winner = 1'b1;
      end
    end else if (valid0) begin
      grant0 = 1'b1;
      winner = 1'b0;
    end else if (valid1) begin
      grant1 = 1'b1;
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/exe_unit_arbiter.sv
// exe_unit_arbiter: shares one fixed-latency execution unit between two requesters,
// one operation in flight, round-robin between requesters, valid/ready on all ports.
// Define EXE_ARB_STATS_EN to add saturating per-requester accepted-operation counters.
module exe_unit_arbiter
  import exe_arb_pkg::*;
#(
  parameter int m     = 4,
  parameter int n     = 2,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rsn,
  exe_unit_arbiter_if.slave   bus
);

  localparam int LAT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

  state_t                state_q, state_d;
  logic [LAT_W-1:0]      lat_cnt;
  req_id_t               last_q;
  req_id_t               winner;
  req_id_t               rsp_id_q;
  logic                  grant0, grant1;
  logic                  take, sample;

  logic [n-1:0]          eu_oper_q;
  logic signed [m-1:0]   eu_arg_a_q;
  logic signed [m-1:0]   eu_arg_b_q;
  logic [m-1:0]          rsp_result_q;
  logic [STATUS_W-1:0]   rsp_status_q;

  rr_arbiter2 u_rr (
    .valid0 (bus.i_req0_valid),
    .valid1 (bus.i_req1_valid),
    .last   (last_q),
    .grant0 (grant0),
    .grant1 (grant1),
    .winner (winner)
  );

  // next state, accept/sample strobes and request readies; readies are held low while in reset
  always_comb begin
    state_d          = state_q;
    take             = 1'b0;
    sample           = 1'b0;
    bus.o_req0_ready = 1'b0;
    bus.o_req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.o_req0_ready = grant0 & i_rsn;
        bus.o_req1_ready = grant1 & i_rsn;
        if (grant0 || grant1) begin
          take    = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          sample  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register; reset drops any operation or response in flight
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // latency countdown: loaded on accept, counts down to zero while waiting
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      lat_cnt <= '0;
    end else if (take) begin
      lat_cnt <= LAT_W'(LAT);
    end else if (state_q == WAIT && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // capture the winner's operation, its id and the round-robin history on accept
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      eu_oper_q  <= '0;
      eu_arg_a_q <= '0;
      eu_arg_b_q <= '0;
      rsp_id_q   <= 1'b0;
      last_q     <= 1'b1;
    end else if (take) begin
      rsp_id_q <= winner;
      last_q   <= winner;
      if (winner == 1'b1) begin
        eu_oper_q  <= bus.i_req1_oper;
        eu_arg_a_q <= bus.i_req1_argA;
        eu_arg_b_q <= bus.i_req1_argB;
      end else begin
        eu_oper_q  <= bus.i_req0_oper;
        eu_arg_a_q <= bus.i_req0_argA;
        eu_arg_b_q <= bus.i_req0_argB;
      end
    end
  end

  // sample the execution unit outputs once the latency has elapsed
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      rsp_result_q <= '0;
      rsp_status_q <= '0;
    end else if (sample) begin
      rsp_result_q <= bus.i_eu_result;
      rsp_status_q <= bus.i_eu_status;
    end
  end

  assign bus.o_eu_oper    = eu_oper_q;
  assign bus.o_eu_argA    = eu_arg_a_q;
  assign bus.o_eu_argB    = eu_arg_b_q;
  assign bus.o_rsp_valid  = (state_q == RESP);
  assign bus.o_rsp_id     = rsp_id_q;
  assign bus.o_rsp_result = rsp_result_q;
  assign bus.o_rsp_status = rsp_status_q;
  assign bus.o_busy       = (state_q != IDLE);

`ifdef EXE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // count accepted operations per requester, sticking at all-ones
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (take) begin
      if (winner == 1'b0 && cnt0_q != '1) begin
        cnt0_q <= cnt0_q + 1'b1;
      end
      if (winner == 1'b1 && cnt1_q != '1) begin
        cnt1_q <= cnt1_q + 1'b1;
      end
    end
  end

  assign bus.o_cnt0 = cnt0_q;
  assign bus.o_cnt1 = cnt1_q;
`endif

endmodule
